// File: rtl/fc1_operand_feeder_if.sv
// Operand-feeder bus: pooled feature stream in, FC operand vectors and control out.
// Ports: start/feat_valid/feat_data/feat_ready (capture side), batch/node (FC address),
//        data/weight_addr/fc_en/done/busy (FC operand and control side).
// master = the FC stage / pooling side, slave = the feeder.
interface fc1_operand_feeder_if #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 32,
  parameter int BATCHES    = 32,
  parameter int NODES      = 64
);
  localparam int BW = $clog2(BATCHES);
  localparam int NW = $clog2(NODES);

  logic                        start;
  logic                        feat_valid;
  logic [DATA_WIDTH-1:0]       feat_data;
  logic                        feat_ready;
  logic [BW-1:0]               batch;
  logic [NW-1:0]               node;
  logic [LANES*DATA_WIDTH-1:0] data;
  logic [NW+BW-1:0]            weight_addr;
  logic                        fc_en;
  logic                        done;
  logic                        busy;

  modport master (
    output start, feat_valid, feat_data, batch, node,
    input  feat_ready, data, weight_addr, fc_en, done, busy
  );

  modport slave (
    input  start, feat_valid, feat_data, batch, node,
    output feat_ready, data, weight_addr, fc_en, done, busy
  );
endinterface

// File: rtl/fc1_operand_feeder.sv
// Captures 1024 pooled features into a 32-bank buffer, then feeds the FC stage 32-lane vectors.
// Latency: data 2 cycles after batch, weight_addr 1 cycle after {node,batch}.
// Backpressure: feat_ready high only in FILL; fc_en runs a fixed count, no stall input.
// Ports: clk, rst_n (async active-low), ifc (slave modport of fc1_operand_feeder_if).
module fc1_operand_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 32,
  parameter int BATCHES    = 32,
  parameter int NODES      = 64,
  parameter int PIPE_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fc1_operand_feeder_if.slave   ifc
);

  localparam int LW         = $clog2(LANES);
  localparam int BW         = $clog2(BATCHES);
  localparam int FW         = $clog2(LANES*BATCHES);
  localparam int RUN_CYCLES = NODES*BATCHES + PIPE_DEPTH;
  localparam int RW         = $clog2(RUN_CYCLES);

  localparam logic [FW-1:0] FEAT_LAST = FW'(LANES*BATCHES - 1);
  localparam logic [RW-1:0] RUN_LAST  = RW'(RUN_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

  state_t               state, state_nxt;
  logic [FW-1:0]        wr_cnt;
  logic [RW-1:0]        run_cnt;
  logic                 wr_en;
  logic [BW-1:0]        rd_row;
  logic [LANES*DATA_WIDTH-1:0] data_q;
  logic [$bits(ifc.weight_addr)-1:0] waddr_q;
  logic                 feat_ready_c, fc_en_c, done_c, busy_c;

  // Bank k holds features k, k+LANES, k+2*LANES ...; one row across all banks is a batch.
  logic [DATA_WIDTH-1:0] mem [LANES][BATCHES];

  assign wr_en = (state == FILL) && ifc.feat_valid;

  // Buffer is not reset; contents only change during FILL.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_cnt[LW-1:0]][wr_cnt[FW-1:LW]] <= ifc.feat_data;
    end
  end

  // Read pipeline runs regardless of state: address register, then bank output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_row  <= '0;
      data_q  <= '0;
      waddr_q <= '0;
    end else begin
      rd_row  <= ifc.batch;
      waddr_q <= {ifc.node, ifc.batch};
      for (int k = 0; k < LANES; k++) begin
        data_q[k*DATA_WIDTH +: DATA_WIDTH] <= mem[k][rd_row];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      wr_cnt  <= '0;
      run_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && ifc.start) begin
        wr_cnt <= '0;
      end else if (wr_en) begin
        wr_cnt <= wr_cnt + FW'(1);
      end
      // Counter sits at 0 outside RUN so the first fc_en cycle is run cycle 0.
      if (state == RUN) begin
        run_cnt <= run_cnt + RW'(1);
      end else begin
        run_cnt <= '0;
      end
    end
  end

  // Control outputs decode the state register directly, so reset drops them immediately.
  always_comb begin
    state_nxt    = state;
    feat_ready_c = 1'b0;
    fc_en_c      = 1'b0;
    done_c       = 1'b0;
    busy_c       = 1'b0;
    case (state)
      IDLE: begin
        if (ifc.start) state_nxt = FILL;
      end
      FILL: begin
        feat_ready_c = 1'b1;
        busy_c       = 1'b1;
        if (ifc.feat_valid && wr_cnt == FEAT_LAST) state_nxt = RUN;
      end
      RUN: begin
        fc_en_c = 1'b1;
        busy_c  = 1'b1;
        if (run_cnt == RUN_LAST) state_nxt = DONE;
      end
      DONE: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ifc.feat_ready  = feat_ready_c;
  assign ifc.fc_en       = fc_en_c;
  assign ifc.done        = done_c;
  assign ifc.busy        = busy_c;
  assign ifc.data        = data_q;
  assign ifc.weight_addr = waddr_q;

endmodule

// File: tb/tb_fc1_operand_feeder.sv
module tb_fc1_operand_feeder;

  localparam int DW      = 16;
  localparam int LANES   = 32;
  localparam int BATCHES = 32;
  localparam int NFEAT   = LANES*BATCHES;
  localparam int RUN_LEN = 64*32 + 8;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Expected buffer contents, indexed by feature number.
  logic [DW-1:0] model_mem [NFEAT];

  fc1_operand_feeder_if bus ();

  fc1_operand_feeder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ifc   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
  endtask

  // Lane k of the vector for batch b is feature b*LANES+k.
  function automatic logic [LANES*DW-1:0] vec(input int b);
    logic [LANES*DW-1:0] v;
    for (int k = 0; k < LANES; k++) v[k*DW +: DW] = model_mem[b*LANES + k];
    return v;
  endfunction

  // Drives one full capture; counts transfers and records them in the model.
  // mode 0: random data, valid toggling; mode 1: constant val, valid always high.
  task automatic do_fill(input int mode, input logic [DW-1:0] val, output int n, output bit fin);
    logic [DW-1:0] d;
    logic          v;
    n   = 0;
    fin = 0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 0; c < 4000 && !fin; c++) begin
      if (!bus.feat_ready) begin
        fin = 1;
      end else begin
        v = (mode == 1) ? 1'b1 : (c % 2 == 0);
        d = (mode == 1) ? val : DW'($urandom);
        bus.feat_valid = v;
        bus.feat_data  = d;
        if (v) begin
          if (n < NFEAT) model_mem[n] = d;
          n++;
        end
        step();
      end
    end
    bus.feat_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 0; bus.feat_valid = 0; bus.feat_data = '0; bus.batch = '0; bus.node = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.feat_ready !== 1'b0) begin n_bad++; $display("FAIL reset_feat_ready: got %b want 0", bus.feat_ready); end
    n_cmp++; if (bus.fc_en !== 1'b0) begin n_bad++; $display("FAIL reset_fc_en: got %b want 0", bus.fc_en); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    step(); step();
    rst_n = 1'b1;
    step();
    // Enter FILL, push a few features, then pull reset in the middle of a cycle.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0; bus.node = 6'd3; bus.batch = 5'd7; bus.feat_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.feat_data = DW'(i + 1);
      step();
    end
    bus.feat_valid = 1'b0;
    n_cmp++; if (bus.feat_ready !== 1'b1) begin n_bad++; $display("FAIL pre_reset_fill: feat_ready got %b want 1", bus.feat_ready); end
    n_cmp++; if (bus.weight_addr !== 11'h067) begin n_bad++; $display("FAIL pre_reset_waddr: got %h want 067", bus.weight_addr); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.feat_ready !== 1'b0) begin n_bad++; $display("FAIL midreset_feat_ready: got %b want 0", bus.feat_ready); end
    n_cmp++; if (bus.fc_en !== 1'b0) begin n_bad++; $display("FAIL midreset_fc_en: got %b want 0", bus.fc_en); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL midreset_done: got %b want 0", bus.done); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL midreset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.data !== '0) begin n_bad++; $display("FAIL midreset_data: got %h want 0", bus.data); end
    n_cmp++; if (bus.weight_addr !== '0) begin n_bad++; $display("FAIL midreset_waddr: got %h want 0", bus.weight_addr); end
    bus.node = '0; bus.batch = '0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fill_ramp();
    int rdy = 0, bsy = 0, fce = 0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < NFEAT; i++) begin
      if (bus.feat_ready) rdy++;
      if (bus.busy) bsy++;
      if (bus.fc_en) fce++;
      bus.feat_valid = 1'b1;
      bus.feat_data  = DW'(i);
      model_mem[i]   = DW'(i);
      step();
    end
    bus.feat_valid = 1'b0;
    n_cmp++; if (rdy !== NFEAT) begin n_bad++; $display("FAIL ramp_ready_cycles: got %0d want %0d", rdy, NFEAT); end
    n_cmp++; if (bsy !== NFEAT) begin n_bad++; $display("FAIL ramp_busy_cycles: got %0d want %0d", bsy, NFEAT); end
    n_cmp++; if (fce !== 0) begin n_bad++; $display("FAIL ramp_fc_en_in_fill: got %0d want 0", fce); end
    n_cmp++; if (bus.feat_ready !== 1'b0) begin n_bad++; $display("FAIL ramp_ready_after: got %b want 0", bus.feat_ready); end
    n_cmp++; if (bus.fc_en !== 1'b1) begin n_bad++; $display("FAIL ramp_fc_en_rise: got %b want 1", bus.fc_en); end
  endtask

  // Entered at the first fc_en cycle; a start pulse is injected mid-run.
  task automatic test_run_count(input string tag);
    int high = 0, dones = 0, last_fc = -1, done_at = -1, bad = 0;
    bit fin = 0;
    for (int c = 0; c < 3000 && !fin; c++) begin
      if (bus.fc_en) begin high++; last_fc = c; end
      if (bus.done) begin dones++; done_at = c; end
      if (bus.feat_ready && (bus.fc_en || bus.done)) bad++;
      if (done_at >= 0 && c > done_at && (bus.busy || bus.feat_ready || bus.fc_en)) bad++;
      if (done_at >= 0 && c >= done_at + 4) fin = 1;
      bus.start = (c == 700);
      step();
    end
    bus.start = 1'b0;
    n_cmp++; if (fin !== 1'b1) begin n_bad++; $display("FAIL %s_timeout: done not seen, fc_en cycles %0d", tag, high); end
    n_cmp++; if (high !== RUN_LEN) begin n_bad++; $display("FAIL %s_fc_en_cycles: got %0d want %0d", tag, high, RUN_LEN); end
    n_cmp++; if (dones !== 1) begin n_bad++; $display("FAIL %s_done_pulses: got %0d want 1", tag, dones); end
    n_cmp++; if (done_at !== last_fc + 1) begin n_bad++; $display("FAIL %s_done_timing: got cycle %0d want %0d", tag, done_at, last_fc + 1); end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL %s_idle_after_done: got %0d bad cycles want 0", tag, bad); end
  endtask

  task automatic test_read_path();
    logic [4:0] hb [64];
    logic [5:0] hn [64];
    bus.batch = 5'd5; bus.node = 6'd3;
    step();
    n_cmp++; if (bus.weight_addr !== 11'h065) begin n_bad++; $display("FAIL waddr_3_5: got %h want 065", bus.weight_addr); end
    bus.batch = 5'd7; bus.node = 6'd3;
    step();
    n_cmp++; if (bus.data[15:0] !== 16'd160) begin n_bad++; $display("FAIL lane0_b5: got %0d want 160", bus.data[15:0]); end
    n_cmp++; if (bus.data[511:496] !== 16'd191) begin n_bad++; $display("FAIL lane31_b5: got %0d want 191", bus.data[511:496]); end
    n_cmp++; if (bus.weight_addr !== 11'h067) begin n_bad++; $display("FAIL waddr_3_7: got %h want 067", bus.weight_addr); end
    for (int k = 0; k < 50; k++) begin
      if (k >= 1) begin
        n_cmp++; if (bus.weight_addr !== {hn[k-1], hb[k-1]}) begin n_bad++; $display("FAIL rand_waddr_%0d: got %h want %h", k, bus.weight_addr, {hn[k-1], hb[k-1]}); end
      end
      if (k >= 2) begin
        n_cmp++; if (bus.data !== vec(hb[k-2])) begin n_bad++; $display("FAIL rand_data_%0d: got %h want %h", k, bus.data, vec(hb[k-2])); end
      end
      hb[k] = 5'($urandom);
      hn[k] = 6'($urandom);
      bus.batch = hb[k];
      bus.node  = hn[k];
      step();
    end
  endtask

  task automatic test_read_all(input string tag);
    for (int k = 0; k < BATCHES + 2; k++) begin
      if (k >= 2) begin
        n_cmp++; if (bus.data !== vec(k - 2)) begin n_bad++; $display("FAIL %s_batch%0d: got %h want %h", tag, k - 2, bus.data, vec(k - 2)); end
      end
      if (k < BATCHES) bus.batch = 5'(k);
      step();
    end
  endtask

  task automatic test_fill_gaps();
    int n, pre = 0;
    bit fin;
    for (int c = 0; c < 5; c++) begin
      if (bus.feat_ready) pre++;
      step();
    end
    n_cmp++; if (pre !== 0) begin n_bad++; $display("FAIL gaps_ready_idle: got %0d want 0", pre); end
    do_fill(0, '0, n, fin);
    n_cmp++; if (fin !== 1'b1) begin n_bad++; $display("FAIL gaps_timeout: fill did not finish, %0d transfers", n); end
    n_cmp++; if (n !== NFEAT) begin n_bad++; $display("FAIL gaps_transfers: got %0d want %0d", n, NFEAT); end
    n_cmp++; if (bus.fc_en !== 1'b1) begin n_bad++; $display("FAIL gaps_fc_en_rise: got %b want 1", bus.fc_en); end
    test_run_count("gaps_run");
    test_read_all("gaps_read");
  endtask

  task automatic test_back_to_back_reset();
    int n, dones = 0;
    bit fin;
    do_fill(0, '0, n, fin);
    n_cmp++; if (fin !== 1'b1 || n !== NFEAT) begin n_bad++; $display("FAIL rr_first_fill: got %0d transfers fin %b want %0d", n, fin, NFEAT); end
    for (int c = 0; c < 1000; c++) begin
      if (bus.done) dones++;
      step();
    end
    n_cmp++; if (bus.fc_en !== 1'b1) begin n_bad++; $display("FAIL rr_run_1000: fc_en got %b want 1", bus.fc_en); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.fc_en !== 1'b0) begin n_bad++; $display("FAIL rr_fc_en_drop: got %b want 0", bus.fc_en); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rr_busy_drop: got %b want 0", bus.busy); end
    step();
    if (bus.done) dones++;
    rst_n = 1'b1;
    step();
    if (bus.done) dones++;
    n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL rr_no_done_on_abort: got %0d want 0", dones); end
    do_fill(1, 16'h8001, n, fin);
    n_cmp++; if (fin !== 1'b1 || n !== NFEAT) begin n_bad++; $display("FAIL rr_refill: got %0d transfers fin %b want %0d", n, fin, NFEAT); end
    test_run_count("rr_run");
    test_read_all("rr_read");
  endtask

  initial begin
    rst_n = 1'b1;
    bus.start = 0; bus.feat_valid = 0; bus.feat_data = '0; bus.batch = '0; bus.node = '0;
    test_reset();
    test_fill_ramp();
    test_run_count("ramp_run");
    test_read_path();
    test_fill_gaps();
    test_back_to_back_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
